btn_conditioner: RTL

//  Input conditioning stage that sits ahead of the up/down counter and FND display path.
//  Raw push-buttons are synchronised to clk and debounced. The block then emits clean

---
 rtl/btn_conditioner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Push-button front end: per-channel 2-FF synchroniser, debounce, press/release pulses, toggle and auto-repeat.
// Define LONG_PRESS_EN to build the hold/auto-repeat FSM; otherwise btn_rpt mirrors btn_p.
module btn_conditioner #(
    parameter int N_BTN             = 4,
    parameter int DEB_CYC           = 100000,
    parameter int REPEAT_DELAY_CYC  = 50000000,
    parameter int REPEAT_PERIOD_CYC = 10000000
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_p,
    output logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] toggle,
    output logic [N_BTN-1:0] btn_rpt
);

    localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic [N_BTN-1:0]            sync1_q, sync2_q;
    logic [N_BTN-1:0]            level_q, level_d;
    logic [N_BTN-1:0]            p_q, p_d;
    logic [N_BTN-1:0]            n_q, n_d;
    logic [N_BTN-1:0]            tog_q, tog_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Acceptance happens on the count's last step, so the counter never passes CNT_LAST.
    always_comb begin
        level_d = level_q;
        p_d     = '0;
        n_d     = '0;
        cnt_d   = cnt_q;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = sync2_q[i];
                    p_d[i]     = sync2_q[i];
                    n_d[i]     = ~sync2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
        tog_d = tog_q ^ p_d;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            p_q     <= '0;
            n_q     <= '0;
            tog_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            p_q     <= p_d;
            n_q     <= n_d;
            tog_q   <= tog_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_p     = p_q;
    assign btn_n     = n_q;
    assign toggle    = tog_q;

`ifdef LONG_PRESS_EN
    // state  | meaning
    // IDLE   | button released, timer parked at 0
    // HOLD   | press accepted, timing the initial repeat delay
    // REPEAT | held past the delay, pulsing every repeat period
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD_CYC - 1);

    logic [N_BTN-1:0][1:0]       st_q, st_d;
    logic [N_BTN-1:0][TMR_W-1:0] tmr_q, tmr_d;
    logic [N_BTN-1:0]            rpt_q, rpt_d;

    // Press/release decisions use the same-edge debounce result so btn_rpt lines up with btn_p.
    always_comb begin
        st_d  = st_q;
        tmr_d = tmr_q;
        rpt_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            case (st_q[i])
                ST_IDLE: begin
                    tmr_d[i] = '0;
                    if (p_d[i]) begin
                        st_d[i]  = ST_HOLD;
                        rpt_d[i] = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (n_d[i]) begin
                        st_d[i]  = ST_IDLE;
                        tmr_d[i] = '0;
                    end else if (tmr_q[i] == DELAY_LAST) begin
                        st_d[i]  = ST_REPEAT;
                        rpt_d[i] = 1'b1;
                        tmr_d[i] = '0;
                    end else begin
                        tmr_d[i] = tmr_q[i] + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (n_d[i]) begin
                        st_d[i]  = ST_IDLE;
                        tmr_d[i] = '0;
                    end else if (tmr_q[i] == PERIOD_LAST) begin
                        rpt_d[i] = 1'b1;
                        tmr_d[i] = '0;
                    end else begin
                        tmr_d[i] = tmr_q[i] + 1'b1;
                    end
                end
                default: begin
                    st_d[i]  = ST_IDLE;
                    tmr_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            st_q  <= {N_BTN{ST_IDLE}};
            tmr_q <= '0;
            rpt_q <= '0;
        end else begin
            st_q  <= st_d;
            tmr_q <= tmr_d;
            rpt_q <= rpt_d;
        end
    end

    assign btn_rpt = rpt_q;
`else
    assign btn_rpt = p_q;
`endif

endmodule
